rr_mux_arbiter: RTL

Many-to-one gather block for the utility library: merges 2**CTRL valid/ready source channels into one registered output channel using round-robin arbitration. Multi-beat packets stay atomic through a per-source `last` flag. Used wherever several producers (e.g. cache or functional-unit requesters) share a single downstream port. The block is the collecting counterpart of the one-hot `demux` fan-out.

---
 rtl/rr_mux_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin gather of 2**CTRL valid/ready sources into one
// registered output channel. Multi-beat packets (terminated by in_last) are
// kept atomic by locking the grant to the packet owner until its last beat.
module rr_mux_arbiter #(
    parameter int CTRL       = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid [2**CTRL],
    input  logic [DATA_WIDTH-1:0] in_data  [2**CTRL],
    input  logic                  in_last  [2**CTRL],
    output logic                  in_ready [2**CTRL],
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [CTRL-1:0]       out_sel,
    input  logic                  out_ready
);
    localparam int N = 2**CTRL;

    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [CTRL-1:0] ptr_reg;
    logic [CTRL-1:0] ptr_next;
    logic [CTRL-1:0] owner_reg;
    logic [CTRL-1:0] owner_next;

    logic [N-1:0]    valid_vec;
    logic [N-1:0]    last_vec;
    logic            rr_found;
    logic [CTRL-1:0] rr_grant;
    logic [CTRL-1:0] grant;
    logic            req;
    logic            free;
    logic            accept;

    // Flatten per-source request/last flags and fan the grant back out as in_ready.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_src
            assign valid_vec[gi] = in_valid[gi];
            assign last_vec[gi]  = in_last[gi];
            assign in_ready[gi]  = accept && (grant == CTRL'(gi));
        end
    endgenerate

    // Round-robin search: first requester after ptr, wrapping; offset N lands on ptr itself.
    always_comb begin
        logic [CTRL-1:0] idx;
        rr_found = 1'b0;
        rr_grant = '0;
        idx      = '0;
        for (int k = 1; k <= N; k++) begin
            idx = ptr_reg + CTRL'(k);
            if (!rr_found && valid_vec[idx]) begin
                rr_found = 1'b1;
                rr_grant = idx;
            end
        end
    end

    // Grant selection, accept decision and next-state logic for the ARB/LOCKED FSM.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        free       = !out_valid || out_ready;
        grant      = rr_grant;
        req        = rr_found;
        if (state_reg == ST_LOCKED) begin
            grant = owner_reg;
            req   = valid_vec[owner_reg];
        end
        accept = free && req;

        case (state_reg)
            ST_ARB: begin
                if (accept) begin
                    ptr_next = grant;
                    if (!last_vec[grant]) begin
                        state_next = ST_LOCKED;
                        owner_next = grant;
                    end
                end
            end
            ST_LOCKED: begin
                // ptr is frozen while a packet owns the output.
                if (accept && last_vec[grant]) begin
                    state_next = ST_ARB;
                end
            end
            default: begin
                state_next = ST_ARB;
            end
        endcase
    end

    // FSM state, round-robin pointer and packet owner; ptr resets to N-1 so source 0 goes first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_ARB;
            ptr_reg   <= '1;
            owner_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
        end
    end

    // Output register: load on accept, empty when drained with nothing new, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data[grant];
            out_last  <= last_vec[grant];
            out_sel   <= grant;
        end else if (free) begin
            out_valid <= 1'b0;
        end
    end

endmodule
